// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM. It assembles 10-bit command
// frames {cmd[1:0], payload[7:0]} from MOSI, strobes them out on rx_data/rx_valid,
// and serialises the RAM's 8-bit read answer onto MISO after a read-data frame.
module spi_slave_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t      state, state_nxt;

  logic [3:0]  bit_cnt;       // frame bits sampled so far, saturates at 10
  logic [9:0]  rx_shift;
  logic [7:0]  tx_shift;      // remaining read-data bits, MSB goes out next
  logic [2:0]  tx_cnt;        // read-data bits still to drive after the first
  logic        tx_busy;
  logic        tx_done;       // answer already shifted for this frame
  logic        rd_addr_done;  // a read address is latched; next 1x frame is read data

  logic        abort;
  logic        in_frame;
  logic        frame_last;
  logic        tx_start;

  // Leaving a transaction: slave select released in any active state.
  assign abort      = (state != IDLE) && SS_n;
  assign in_frame   = !SS_n && ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA));
  assign frame_last = in_frame && (bit_cnt == 4'd9);
  assign tx_start   = !SS_n && (state == READ_DATA) && (bit_cnt == 4'd10) &&
                      tx_valid && !tx_busy && !tx_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: bit 9 of the frame picks the write or read path.
  always_comb begin
    // NOTE: next state defaults to the current one so every path assigns it and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_done) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Receive path: shift MOSI in, publish the frame with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the strobe default low and be overridden below without ordering hazards.
      rx_valid <= 1'b0;
      if (abort) begin
        bit_cnt <= '0;
      end else if (state == CHK_CMD) begin
        rx_shift <= {9'b0, MOSI};
        bit_cnt  <= 4'd1;
      end else if (in_frame && (bit_cnt < 4'd10)) begin
        rx_shift <= {rx_shift[8:0], MOSI};
        bit_cnt  <= bit_cnt + 4'd1;
        if (frame_last) begin
          rx_data  <= {rx_shift[8:0], MOSI};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit path: shift the RAM answer out MSB first, once per read-data frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MISO         <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_done <= 1'b0;
    end else if (abort) begin
      // The address flag survives an abort so a retried read still finds it.
      MISO    <= 1'b0;
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if ((state == READ_ADD) && frame_last) rd_addr_done <= 1'b1;
      if (tx_start) begin
        MISO     <= tx_data[7];
        tx_shift <= {tx_data[6:0], 1'b0};
        tx_cnt   <= 3'd7;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt != 3'd0) begin
          MISO     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
          tx_cnt   <= tx_cnt - 3'd1;
        end else begin
          MISO         <= 1'b0;
          tx_busy      <= 1'b0;
          tx_done      <= 1'b1;
          rd_addr_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: write frames, read address/data sequence,
// abort, reset during the MISO shift, and back-to-back frames.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_pass  = 0;
  int n_total = 0;

  spi_slave_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs, let one rising edge pass, settle 1 time unit after it.
  task automatic step(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  // From IDLE: SS_n-low edge, then 10 frame bits MSB first; strobe only on the 10th.
  task automatic send_frame(input string tag, input logic [9:0] f);
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      step(1'b0, f[i]);
      check($sformatf("%s rx_valid bit%0d", tag, i), rx_valid, (i == 0));
    end
    check({tag, " rx_data"}, rx_data, f);
    check({tag, " miso idle"}, MISO, 1'b0);
  endtask

  // Read-data answer: one MISO bit per edge, starting at the tx_valid edge.
  task automatic expect_miso(input string tag, input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("%s miso bit%0d", tag, 7 - i), MISO, bits[7 - i]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset miso", MISO, 1'b0);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_data", rx_data, 10'h000);
    rst_n = 1'b1;
    step(1'b1, 1'b0);

    // 1: write address
    send_frame("wr_addr", 10'b00_1010_0101);
    step(1'b1, 1'b0);
    check("wr_addr strobe drop", rx_valid, 1'b0);
    check("wr_addr hold", rx_data, 10'h0A5);

    // 2: write data
    send_frame("wr_data", 10'b01_0011_1100);
    step(1'b1, 1'b0);
    check("wr_data strobe drop", rx_valid, 1'b0);

    // 3: read address then read data; answer 0x3C shifted once
    send_frame("rd_addr", 10'b10_1010_0101);
    step(1'b1, 1'b0);
    send_frame("rd_data", 10'b11_0000_0000);
    step(1'b0, 1'b0);
    check("rd_data strobe drop", rx_valid, 1'b0);
    step(1'b0, 1'b0);
    check("rd_data wait tx_valid", MISO, 1'b0);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    expect_miso("rd_3c", 8'h3C, 8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("rd_3c once %0d", i), MISO, 1'b0);
    end
    tx_valid = 1'b0;
    step(1'b1, 1'b0);

    // Flag cleared: a 1x frame now goes through READ_ADD, so no answer appears
    send_frame("flag_clr", 10'b11_0000_0000);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("flag_clr no tx %0d", i), MISO, 1'b0);
    end
    tx_valid = 1'b0;
    step(1'b1, 1'b0);

    // 4: abort after 5 bits; flag (set by previous frame) must survive
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0]);
      check($sformatf("abort no strobe %0d", i), rx_valid, 1'b0);
    end
    step(1'b1, 1'b0);
    check("abort strobe", rx_valid, 1'b0);
    check("abort rx_data kept", rx_data, 10'h300);
    send_frame("post_abort", 10'b11_0000_0001);
    tx_data  = 8'h9D;
    tx_valid = 1'b1;
    expect_miso("rd_9d", 8'h9D, 4);

    // 5: reset on the edge that would drive bit 3 (a 1)
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    check("midrst miso", MISO, 1'b0);
    check("midrst rx_valid", rx_valid, 1'b0);
    check("midrst rx_data", rx_data, 10'h000);
    step(1'b1, 1'b0);
    send_frame("post_rst", 10'b11_0101_0101);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("post_rst no tx %0d", i), MISO, 1'b0);
    end
    tx_valid = 1'b0;
    step(1'b1, 1'b0);

    // 6: back-to-back frames with a single-cycle SS_n high gap
    send_frame("b2b_a", 10'h0F0);
    step(1'b1, 1'b0);
    check("b2b gap strobe", rx_valid, 1'b0);
    send_frame("b2b_b", 10'h155);
    step(1'b1, 1'b0);
    check("b2b_b strobe drop", rx_valid, 1'b0);
    check("b2b_b hold", rx_data, 10'h155);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
